// File: rtl/piece_queue.sv
// Preview FIFO fed by the piece randomiser: one-shot reroll damps immediate repeats,
// pieces leave through a spawn request/acknowledge handshake.
module piece_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 2
) (
   input  logic                       clka,
   input  logic                       restart,
   input  logic [CW-1:0]              random,
   input  logic                       spawn_req,
   output logic                       spawn_ack,
   output logic [CW-1:0]              spawn_piece,
   output logic [CW-1:0]              next_piece,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ready,
   output logic                       dbg_state
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   // Handshake: spawn_req is a level held by the controller until it sees
   // spawn_ack; spawn_ack is a single-cycle pulse and spawn_piece is valid
   // from that cycle until the next ack.
   state_t            r_state;
   logic [CW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CNTW-1:0]   r_count;
   logic [CW-1:0]     r_last_enq;
   logic              r_last_valid;
   logic              r_reroll_used;
   logic              r_ack;
   logic [CW-1:0]     r_piece;
   logic              r_ready;

   logic              w_can_push;
   logic              w_reject;
   logic              w_push;
   logic              w_pop;

   // Push eligibility is judged on the pre-pop count, so a full queue that
   // pops refills only on the following edge.
   assign w_can_push = (r_count < FULL);
   assign w_reject   = r_last_valid && (random == r_last_enq) && !r_reroll_used;
   assign w_push     = w_can_push && !w_reject;
   assign w_pop      = (r_state == S_RUN) && spawn_req && (r_count != '0) && !r_ack;

   always_ff @(posedge clka) begin
      if (restart) begin
         r_state       <= S_INIT;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_last_enq    <= '0;
         r_last_valid  <= 1'b0;
         r_reroll_used <= 1'b0;
         r_ack         <= 1'b0;
         r_piece       <= '0;
         r_ready       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_can_push) begin
            if (w_reject) begin
               r_reroll_used <= 1'b1;
            end else begin
               r_mem[r_tail] <= random;
               r_tail        <= r_tail + PW'(1);
               r_last_enq    <= random;
               r_last_valid  <= 1'b1;
               r_reroll_used <= 1'b0;
            end
         end

         r_ack <= w_pop;
         if (w_pop) begin
            r_piece <= r_mem[r_head];
            r_head  <= r_head + PW'(1);
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase

         case (r_state)
            S_INIT: begin
               if (w_push && (r_count == FULL - CNTW'(1))) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end
            end
            S_RUN:   r_state <= S_RUN;
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign spawn_ack   = r_ack;
   assign spawn_piece = r_piece;
   assign next_piece  = (r_count == '0) ? '0 : r_mem[r_head];
   assign count       = r_count;
   assign ready       = r_ready;
   assign dbg_state   = (r_state == S_RUN);

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: fill, reroll, pop/refill, INIT gating,
// held request and mid-operation reset with hand-computed expectations.
module tb_piece_queue;

   localparam int DEPTH = 4;
   localparam int CW    = 2;

   logic          clka;
   logic          restart;
   logic [CW-1:0] random;
   logic          spawn_req;
   logic          spawn_ack;
   logic [CW-1:0] spawn_piece;
   logic [CW-1:0] next_piece;
   logic [2:0]    count;
   logic          ready;
   logic          dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   piece_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clka        (clka),
      .restart     (restart),
      .random      (random),
      .spawn_req   (spawn_req),
      .spawn_ack   (spawn_ack),
      .spawn_piece (spawn_piece),
      .next_piece  (next_piece),
      .count       (count),
      .ready       (ready),
      .dbg_state   (dbg_state)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance one edge; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic expect_state(input string tag, input int c, input int a, input int p,
                               input int nx, input int rdy);
      check({tag, ".count"},       32'(count),       32'(c));
      check({tag, ".ack"},         32'(spawn_ack),   32'(a));
      check({tag, ".piece"},       32'(spawn_piece), 32'(p));
      check({tag, ".next"},        32'(next_piece),  32'(nx));
      check({tag, ".ready"},       32'(ready),       32'(rdy));
   endtask

   initial begin
      restart   = 1'b1;
      random    = '0;
      spawn_req = 1'b0;
      tick();
      tick();
      expect_state("reset", 0, 0, 0, 0, 0);
      check("reset.state", 32'(dbg_state), 32'd0);

      // fill 0,1,2,3
      restart = 1'b0;
      random = 2'd0; tick(); expect_state("fill1", 1, 0, 0, 0, 0);
      random = 2'd1; tick(); expect_state("fill2", 2, 0, 0, 0, 0);
      random = 2'd2; tick(); expect_state("fill3", 3, 0, 0, 0, 0);
      random = 2'd3; tick(); expect_state("fill4", 4, 0, 0, 0, 1);
      check("fill4.state", 32'(dbg_state), 32'd1);
      tick(); expect_state("full_hold", 4, 0, 0, 0, 1);

      // pop with refill, random held at 3
      spawn_req = 1'b1; tick(); expect_state("pop1", 3, 1, 0, 1, 1);
      spawn_req = 1'b0; tick(); expect_state("pop1_rej", 3, 0, 0, 1, 1);
      tick(); expect_state("pop1_refill", 4, 0, 0, 1, 1);

      // held request for 3 cycles: FIFO 1,2,3,3
      spawn_req = 1'b1; tick(); expect_state("held1", 3, 1, 1, 2, 1);
      tick(); expect_state("held2", 3, 0, 1, 2, 1);
      tick(); expect_state("held3", 3, 1, 2, 3, 1);
      spawn_req = 1'b0;

      // reset during the ack cycle with count=3
      restart = 1'b1; tick(); expect_state("midrst", 0, 0, 0, 0, 0);
      check("midrst.state", 32'(dbg_state), 32'd0);
      restart = 1'b0;
      random = 2'd3; tick(); expect_state("rst_first", 1, 0, 0, 3, 0);
      tick(); expect_state("rst_rej", 1, 0, 0, 3, 0);
      tick(); expect_state("rst_acc", 2, 0, 0, 3, 0);

      // reroll 2,2,2,1 plus INIT gating
      restart = 1'b1; tick();
      restart = 1'b0;
      random = 2'd2; tick(); expect_state("rr1", 1, 0, 0, 2, 0);
      tick(); expect_state("rr2", 1, 0, 0, 2, 0);
      tick(); expect_state("rr3", 2, 0, 0, 2, 0);
      spawn_req = 1'b1;
      random = 2'd1; tick(); expect_state("gate1", 3, 0, 0, 2, 0);
      random = 2'd0; tick(); expect_state("gate2", 4, 0, 0, 2, 1);
      tick(); expect_state("gate_ack", 3, 1, 2, 2, 1);
      spawn_req = 1'b0; tick(); expect_state("gate_rej", 3, 0, 2, 2, 1);
      spawn_req = 1'b1; tick(); expect_state("rr_pop2", 3, 1, 2, 1, 1);
      spawn_req = 1'b0; tick(); expect_state("rr_rej2", 3, 0, 2, 1, 1);
      spawn_req = 1'b1; tick(); expect_state("rr_pop3", 3, 1, 1, 0, 1);
      spawn_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
